// File: rtl/id_stage_if.sv
// Bus between the fetch/write-back side and the decode stage.
// The master drives the fetched instruction and write-back port and
// receives the branch redirect plus the registered ID/EX bundle.
interface id_stage_if;
    logic [31:0] PC_in;
    logic [31:0] instruction_in;
    logic        WB_en;
    logic [4:0]  WB_dest;
    logic [31:0] WB_value;

    logic        Br_taken;
    logic [15:0] Br_offset;

    logic        EX_valid;
    logic        EX_wb_en;
    logic        EX_mem_read;
    logic        EX_mem_write;
    logic        EX_use_imm;
    logic [31:0] EX_PC;
    logic [3:0]  EX_cmd;
    logic [31:0] EX_val1;
    logic [31:0] EX_val2;
    logic [31:0] EX_imm;
    logic [4:0]  EX_dest;

    modport master (
        output PC_in, instruction_in, WB_en, WB_dest, WB_value,
        input  Br_taken, Br_offset,
        input  EX_valid, EX_wb_en, EX_mem_read, EX_mem_write, EX_use_imm,
        input  EX_PC, EX_cmd, EX_val1, EX_val2, EX_imm, EX_dest
    );

    modport slave (
        input  PC_in, instruction_in, WB_en, WB_dest, WB_value,
        output Br_taken, Br_offset,
        output EX_valid, EX_wb_en, EX_mem_read, EX_mem_write, EX_use_imm,
        output EX_PC, EX_cmd, EX_val1, EX_val2, EX_imm, EX_dest
    );
endinterface

// File: rtl/id_stage.sv
// Instruction decode stage: IF/ID latch, 32x32 register file with
// write-through bypass, branch resolution in decode and the ID/EX register.
module id_stage (
    input  logic     clk,
    input  logic     rst,
    id_stage_if.slave bus
);
    localparam int DATA_W = 32;

    localparam logic [3:0] CMD_ADD = 4'd0;
    localparam logic [3:0] CMD_SUB = 4'd1;
    localparam logic [3:0] CMD_AND = 4'd2;
    localparam logic [3:0] CMD_OR  = 4'd3;
    localparam logic [3:0] CMD_SLT = 4'd4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    function automatic logic signed [DATA_W-1:0] sext16(input logic [15:0] v);
        return {{(DATA_W-16){v[15]}}, v};
    endfunction

    // IF/ID stage state
    logic              if_valid_p0;
    logic [31:0]       if_pc_p0;
    logic [31:0]       if_instr_p0;

    logic [DATA_W-1:0] rf [32];

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;

    logic              dec_wb_en;
    logic              dec_mem_read;
    logic              dec_mem_write;
    logic              dec_use_imm;
    logic [3:0]        dec_cmd;
    logic [4:0]        dec_dest;
    logic              is_beq;
    logic              is_bne;
    logic              br_taken;

    // ID/EX stage state
    logic              ex_valid_p1;
    logic              ex_wb_en_p1;
    logic              ex_mem_read_p1;
    logic              ex_mem_write_p1;
    logic              ex_use_imm_p1;
    logic [31:0]       ex_pc_p1;
    logic [3:0]        ex_cmd_p1;
    logic [DATA_W-1:0] ex_val1_p1;
    logic [DATA_W-1:0] ex_val2_p1;
    logic signed [DATA_W-1:0] ex_imm_p1;
    logic [4:0]        ex_dest_p1;

    assign op    = if_instr_p0[31:26];
    assign rs    = if_instr_p0[25:21];
    assign rt    = if_instr_p0[20:16];
    assign rd    = if_instr_p0[15:11];
    assign funct = if_instr_p0[5:0];

    // Register file: r0 is never written; the write still commits during a squash.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (bus.WB_en && (bus.WB_dest != 5'd0)) begin
            rf[bus.WB_dest] <= bus.WB_value;
        end
    end

    // Operand reads with write-through bypass so a same-cycle write-back is visible.
    always_comb begin
        rs_data = rf[rs];
        rt_data = rf[rt];
        if (bus.WB_en && (bus.WB_dest == rs)) rs_data = bus.WB_value;
        if (bus.WB_en && (bus.WB_dest == rt)) rt_data = bus.WB_value;
        if (rs == 5'd0) rs_data = '0;
        if (rt == 5'd0) rt_data = '0;
    end

    // Instruction decode; unknown encodings fall through as a NOP.
    always_comb begin
        dec_wb_en     = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_use_imm   = 1'b0;
        dec_cmd       = CMD_ADD;
        dec_dest      = 5'd0;
        is_beq        = 1'b0;
        is_bne        = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    6'h20: begin dec_cmd = CMD_ADD; dec_wb_en = 1'b1; dec_dest = rd; end
                    6'h22: begin dec_cmd = CMD_SUB; dec_wb_en = 1'b1; dec_dest = rd; end
                    6'h24: begin dec_cmd = CMD_AND; dec_wb_en = 1'b1; dec_dest = rd; end
                    6'h25: begin dec_cmd = CMD_OR;  dec_wb_en = 1'b1; dec_dest = rd; end
                    6'h2A: begin dec_cmd = CMD_SLT; dec_wb_en = 1'b1; dec_dest = rd; end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                dec_wb_en   = 1'b1;
                dec_dest    = rt;
                dec_use_imm = 1'b1;
            end
            OP_LW: begin
                dec_wb_en    = 1'b1;
                dec_dest     = rt;
                dec_mem_read = 1'b1;
                dec_use_imm  = 1'b1;
            end
            OP_SW: begin
                dec_mem_write = 1'b1;
                dec_use_imm   = 1'b1;
            end
            OP_BEQ:  is_beq = 1'b1;
            OP_BNE:  is_bne = 1'b1;
            default: ;
        endcase
        if (!if_valid_p0) begin
            dec_wb_en     = 1'b0;
            dec_mem_read  = 1'b0;
            dec_mem_write = 1'b0;
            dec_use_imm   = 1'b0;
            dec_cmd       = CMD_ADD;
            dec_dest      = 5'd0;
            is_beq        = 1'b0;
            is_bne        = 1'b0;
        end
    end

    // Branches resolve in decode using the bypassed operands.
    assign br_taken      = (is_beq && (rs_data == rt_data)) || (is_bne && (rs_data != rt_data));
    assign bus.Br_taken  = br_taken;
    assign bus.Br_offset = if_valid_p0 ? {if_instr_p0[13:0], 2'b00} : 16'd0;

    // IF/ID latch: a taken branch squashes the following fetch (no delay slot).
    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid_p0 <= 1'b0;
            if_pc_p0    <= '0;
            if_instr_p0 <= '0;
        end else begin
            if_valid_p0 <= ~br_taken;
            if_pc_p0    <= bus.PC_in;
            if_instr_p0 <= br_taken ? 32'd0 : bus.instruction_in;
        end
    end

    // ID/EX register loads every cycle; controls are already zero for invalid slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_p1     <= 1'b0;
            ex_wb_en_p1     <= 1'b0;
            ex_mem_read_p1  <= 1'b0;
            ex_mem_write_p1 <= 1'b0;
            ex_use_imm_p1   <= 1'b0;
            ex_pc_p1        <= '0;
            ex_cmd_p1       <= '0;
            ex_val1_p1      <= '0;
            ex_val2_p1      <= '0;
            ex_imm_p1       <= '0;
            ex_dest_p1      <= '0;
        end else begin
            ex_valid_p1     <= if_valid_p0;
            ex_wb_en_p1     <= dec_wb_en;
            ex_mem_read_p1  <= dec_mem_read;
            ex_mem_write_p1 <= dec_mem_write;
            ex_use_imm_p1   <= dec_use_imm;
            ex_pc_p1        <= if_pc_p0;
            ex_cmd_p1       <= dec_cmd;
            ex_val1_p1      <= rs_data;
            ex_val2_p1      <= rt_data;
            ex_imm_p1       <= sext16(if_instr_p0[15:0]);
            ex_dest_p1      <= dec_dest;
        end
    end

    assign bus.EX_valid     = ex_valid_p1;
    assign bus.EX_wb_en     = ex_wb_en_p1;
    assign bus.EX_mem_read  = ex_mem_read_p1;
    assign bus.EX_mem_write = ex_mem_write_p1;
    assign bus.EX_use_imm   = ex_use_imm_p1;
    assign bus.EX_PC        = ex_pc_p1;
    assign bus.EX_cmd       = ex_cmd_p1;
    assign bus.EX_val1      = ex_val1_p1;
    assign bus.EX_val2      = ex_val2_p1;
    assign bus.EX_imm       = ex_imm_p1;
    assign bus.EX_dest      = ex_dest_p1;
endmodule
